// File: rtl/ab_solver.sv
// Guesser for the 1A2B game. It walks the BCD candidates in ascending order and presents the first one consistent with all stored feedback.
// Latency: one candidate per clock in SEARCH, and an accept registers the guess on the next edge. There is no backpressure: the guess is held until fb_valid.
module ab_solver #(
    parameter int          MAX_HIST   = 10,
    parameter logic [15:0] FIRST_CAND = 16'h0123
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        fb_valid,
    input  logic [2:0]  fb_a,
    input  logic [2:0]  fb_b,
    output logic [15:0] guess,
    output logic        guess_valid,
    output logic        busy,
    output logic        solved,
    output logic        fail,
    output logic [3:0]  guess_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEARCH,
        S_PRESENT,
        S_DONE,
        S_FAIL
    } state_t;

    localparam logic [15:0] LAST_CAND = 16'h9876;
    localparam logic [3:0]  HIST_MAX  = 4'(MAX_HIST);

    state_t      state, state_nxt;
    logic [15:0] cand;
    logic [3:0]  hist_cnt;
    logic [15:0] hist_guess [MAX_HIST];
    logic [2:0]  hist_a     [MAX_HIST];
    logic [2:0]  hist_b     [MAX_HIST];
    logic        cand_ok;
    logic        fb_illegal;
    logic        hist_push;

    function automatic logic bcd_legal(input logic [15:0] w);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (w[4*i +: 4] > 4'd9) ok = 1'b0;
            for (int j = i + 1; j < 4; j++)
                if (w[4*i +: 4] == w[4*j +: 4]) ok = 1'b0;
        end
        return ok;
    endfunction

    // The result is {A, B}. Both words are assumed to have distinct digits.
    function automatic logic [5:0] score(input logic [15:0] x, input logic [15:0] y);
        logic [2:0] a;
        logic [2:0] b;
        a = 3'd0;
        b = 3'd0;
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                if (x[4*i +: 4] == y[4*j +: 4]) begin
                    if (i == j) a = a + 3'd1;
                    else        b = b + 3'd1;
                end
        return {a, b};
    endfunction

    function automatic logic [15:0] bcd_inc(input logic [15:0] w);
        logic [15:0] r;
        logic        carry;
        r     = w;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (w[4*i +: 4] >= 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                end else begin
                    r[4*i +: 4] = w[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Every live history entry is checked against the candidate in the same cycle.
    always_comb begin
        cand_ok = bcd_legal(cand);
        for (int h = 0; h < MAX_HIST; h++)
            if (4'(h) < hist_cnt && score(cand, hist_guess[h]) != {hist_a[h], hist_b[h]})
                cand_ok = 1'b0;
    end

    assign fb_illegal = (fb_a > 3'd4) || (fb_b > 3'd4) ||
                        (({1'b0, fb_a} + {1'b0, fb_b}) > 4'd4) ||
                        (fb_a == 3'd3 && fb_b == 3'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        hist_push = 1'b0;
        case (state)
            S_IDLE, S_DONE, S_FAIL: begin
                if (start) state_nxt = S_SEARCH;
            end
            S_SEARCH: begin
                if (cand_ok)                 state_nxt = S_PRESENT;
                else if (cand == LAST_CAND)  state_nxt = S_FAIL;
            end
            S_PRESENT: begin
                if (fb_valid) begin
                    if (fb_illegal)                                    state_nxt = S_FAIL;
                    else if (fb_a == 3'd4)                             state_nxt = S_DONE;
                    else if (hist_cnt == HIST_MAX || guess == LAST_CAND) state_nxt = S_FAIL;
                    else begin
                        state_nxt = S_SEARCH;
                        hist_push = 1'b1;
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            guess       <= 16'heeee;
            cand        <= FIRST_CAND;
            hist_cnt    <= 4'd0;
            guess_count <= 4'd0;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_FAIL: begin
                    if (start) begin
                        guess       <= 16'heeee;
                        cand        <= FIRST_CAND;
                        hist_cnt    <= 4'd0;
                        guess_count <= 4'd0;
                    end
                end
                S_SEARCH: begin
                    if (cand_ok) begin
                        guess       <= cand;
                        guess_count <= (guess_count == 4'd15) ? 4'd15 : guess_count + 4'd1;
                    end else if (cand != LAST_CAND) begin
                        cand <= bcd_inc(cand);
                    end
                end
                S_PRESENT: begin
                    if (hist_push) begin
                        hist_cnt <= hist_cnt + 4'd1;
                        cand     <= bcd_inc(guess);
                    end
                end
                default: ;
            endcase
        end
    end

    // History storage needs no reset, because entries at or above hist_cnt are ignored.
    always_ff @(posedge clk) begin
        if (hist_push) begin
            hist_guess[hist_cnt] <= guess;
            hist_a[hist_cnt]     <= fb_a;
            hist_b[hist_cnt]     <= fb_b;
        end
    end

    assign guess_valid = (state == S_PRESENT);
    assign busy        = (state == S_SEARCH) || (state == S_PRESENT);
    assign solved      = (state == S_DONE);
    assign fail        = (state == S_FAIL);

endmodule

// File: tb/tb_ab_solver.sv
// Directed bench for ab_solver. A decimal-arithmetic game model predicts every cycle, and literal expectations pin the model.
module tb_ab_solver;

    localparam int MAXH = 10;
    localparam int M_IDLE = 0, M_SEARCH = 1, M_PRESENT = 2, M_DONE = 3, M_FAIL = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        fb_valid;
    logic [2:0]  fb_a;
    logic [2:0]  fb_b;
    logic [15:0] guess;
    logic        guess_valid;
    logic        busy;
    logic        solved;
    logic        fail;
    logic [3:0]  guess_count;

    int checks = 0;
    int errors = 0;

    ab_solver #(.MAX_HIST(MAXH), .FIRST_CAND(16'h0123)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .fb_valid(fb_valid),
        .fb_a(fb_a), .fb_b(fb_b), .guess(guess), .guess_valid(guess_valid),
        .busy(busy), .solved(solved), .fail(fail), .guess_count(guess_count)
    );

    always #5 clk = ~clk;

    // ---------------- game model (decimal arithmetic) ----------------
    int          m_mode  = M_IDLE;
    logic [15:0] m_guess = 16'heeee;
    int          m_gc    = 0;
    int          m_left  = 0;
    int          m_next  = 0;
    int          hg[$];
    int          ha[$];
    int          hb[$];

    function automatic int dig(input int n, input int p);
        int d;
        d = 1;
        for (int i = 0; i < p; i++) d = d * 10;
        return (n / d) % 10;
    endfunction

    function automatic logic [9:0] dmask(input int n);
        logic [9:0] m;
        m = '0;
        for (int p = 0; p < 4; p++) m[dig(n, p)] = 1'b1;
        return m;
    endfunction

    function automatic bit consistent(input int n);
        int a;
        int common;
        if ($countones(dmask(n)) != 4) return 1'b0;
        for (int i = 0; i < hg.size(); i++) begin
            a = 0;
            for (int p = 0; p < 4; p++) if (dig(n, p) == dig(hg[i], p)) a++;
            common = $countones(dmask(n) & dmask(hg[i]));
            if (a != ha[i] || (common - a) != hb[i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int first_ok(input int from, output int steps);
        steps = 0;
        for (int n = from; n <= 9999; n++) begin
            steps++;
            if (consistent(n)) return n;
            if (n == 9876) return -1;
        end
        return -1;
    endfunction

    function automatic logic [15:0] to_bcd(input int n);
        return {4'(dig(n, 3)), 4'(dig(n, 2)), 4'(dig(n, 1)), 4'(dig(n, 0))};
    endfunction

    function automatic int from_bcd(input logic [15:0] w);
        return int'(w[15:12]) * 1000 + int'(w[11:8]) * 100 + int'(w[7:4]) * 10 + int'(w[3:0]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        int fa;
        int fbv;
        if (!rst_n) begin
            m_mode = M_IDLE; m_guess = 16'heeee; m_gc = 0; m_left = 0;
            hg.delete(); ha.delete(); hb.delete();
        end else begin
            fa  = int'(fb_a);
            fbv = int'(fb_b);
            case (m_mode)
                M_IDLE, M_DONE, M_FAIL: if (start) begin
                    hg.delete(); ha.delete(); hb.delete();
                    m_gc = 0; m_guess = 16'heeee;
                    m_next = first_ok(123, m_left);
                    m_mode = M_SEARCH;
                end
                M_SEARCH: begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_next < 0) m_mode = M_FAIL;
                        else begin
                            m_mode  = M_PRESENT;
                            m_guess = to_bcd(m_next);
                            m_gc    = (m_gc < 15) ? m_gc + 1 : 15;
                        end
                    end
                end
                M_PRESENT: if (fb_valid) begin
                    if (fa > 4 || fbv > 4 || fa + fbv > 4 || (fa == 3 && fbv == 1)) m_mode = M_FAIL;
                    else if (fa == 4) m_mode = M_DONE;
                    else if (hg.size() == MAXH || m_guess == 16'h9876) m_mode = M_FAIL;
                    else begin
                        hg.push_back(from_bcd(m_guess)); ha.push_back(fa); hb.push_back(fbv);
                        m_next = first_ok(from_bcd(m_guess) + 1, m_left);
                        m_mode = M_SEARCH;
                    end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic give_fb(input int a, input int b);
        fb_a = 3'(a); fb_b = 3'(b); fb_valid = 1'b1;
        @(negedge clk);
        fb_valid = 1'b0;
    endtask

    task automatic wait_gv(input string name, input int budget);
        int n;
        n = 0;
        while (guess_valid !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(guess_valid), 32'd1);
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // ---------------- stimulus and cycle compare ----------------
    initial begin
        rst_n = 1'b0; start = 1'b0; fb_valid = 1'b0; fb_a = '0; fb_b = '0;
        fork
            forever begin
                @(negedge clk);
                if (rst_n)
                    check("cycle", {8'h0, guess, guess_valid, busy, solved, fail, guess_count},
                          {8'h0, m_guess, (m_mode == M_PRESENT),
                           (m_mode == M_SEARCH || m_mode == M_PRESENT),
                           (m_mode == M_DONE), (m_mode == M_FAIL), 4'(m_gc)});
            end
        join_none

        repeat (2) @(negedge clk);
        check("rst_guess", 32'(guess), 32'heeee);
        check("rst_flags", {28'h0, guess_valid, busy, solved, fail}, 32'h0);
        check("rst_count", 32'(guess_count), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Feedback in IDLE must do nothing.
        give_fb(4, 0);
        check("idle_fb_solved", 32'(solved), 32'd0);
        check("idle_fb_count", 32'(guess_count), 32'd0);

        // Immediate win
        do_start();
        check("t1_busy", 32'(busy), 32'd1);
        @(negedge clk);
        check("t1_guess", 32'(guess), 32'h0123);
        check("t1_gv", 32'(guess_valid), 32'd1);
        give_fb(4, 0);
        check("t1_solved", 32'(solved), 32'd1);
        check("t1_count", 32'(guess_count), 32'd1);
        check("t1_busy_end", 32'(busy), 32'd0);

        // Second-guess win, with a stray fb in SEARCH and a start in PRESENT
        do_start();
        wait_gv("t2_gv1", 4);
        give_fb(0, 0);
        give_fb(4, 0);
        check("t2_search_fb_count", 32'(guess_count), 32'd1);
        wait_gv("t2_gv2", 6000);
        check("t2_guess", 32'(guess), 32'h4567);
        check("t2_count", 32'(guess_count), 32'd2);
        do_start();
        check("t2_start_ignored", 32'(guess), 32'h4567);
        check("t2_start_gv", 32'(guess_valid), 32'd1);
        give_fb(4, 0);
        check("t2_solved", 32'(solved), 32'd1);

        // Exhaustion
        do_start();
        wait_gv("t3_gv1", 4);
        give_fb(0, 0);
        wait_gv("t3_gv2", 6000);
        give_fb(0, 0);
        wait_idle("t3_end", 8000);
        check("t3_fail", 32'(fail), 32'd1);
        check("t3_gv", 32'(guess_valid), 32'd0);

        // Illegal feedback
        do_start();
        wait_gv("t4_gv_a", 4);
        give_fb(3, 1);
        check("t4_fail_31", 32'(fail), 32'd1);
        do_start();
        wait_gv("t4_gv_b", 4);
        give_fb(2, 3);
        check("t4_fail_23", 32'(fail), 32'd1);

        // Bulls/cows scoring path
        do_start();
        wait_gv("t5_gv1", 4);
        give_fb(0, 4);
        wait_gv("t5_gv2", 3000);
        check("t5_guess2", 32'(guess), 32'h1032);
        give_fb(2, 2);
        wait_gv("t5_gv3", 1000);
        check("t5_guess3", 32'(guess), 32'h1230);
        check("t5_count", 32'(guess_count), 32'd3);
        give_fb(4, 0);
        check("t5_solved", 32'(solved), 32'd1);

        // Async reset mid-SEARCH
        do_start();
        wait_gv("t6_gv1", 4);
        give_fb(0, 0);
        repeat (10) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_guess", 32'(guess), 32'heeee);
        check("t6_rst_flags", {28'h0, guess_valid, busy, solved, fail}, 32'h0);
        check("t6_rst_count", 32'(guess_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        do_start();
        @(negedge clk);
        check("t6_restart_guess", 32'(guess), 32'h0123);
        check("t6_restart_count", 32'(guess_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ab_solver.md
Name: ab_solver

Overview:
- Automatic guesser for the 1A2B game; the opposite end of the game's scoring interface.
- The game side holds the secret and scores guesses. This block produces the guesses and consumes the A/B feedback.
- It walks the 4-digit BCD candidate space in ascending order. It presents the first candidate that has distinct digits and is consistent with every stored (guess, A, B) history entry.
- It sits between the display/feedback front end (human or Game-side scorer) and the 7-seg signal mux.

Parameters:
- MAX_HIST, 10: history depth; the maximum number of non-winning feedbacks stored. Legal range 1..15.
- FIRST_CAND, 16'h0123: first candidate examined after start, as BCD nibbles.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a new game
- fb_valid  input  1  one-cycle pulse; fb_a/fb_b apply to the presented guess
- fb_a  input  3  A count (0..4)
- fb_b  input  3  B count (0..4)
- guess  output  16  presented guess; [15:12] leftmost digit … [3:0] rightmost digit, BCD
- guess_valid  output  1  high while guess awaits feedback
- busy  output  1  high in SEARCH or PRESENT
- solved  output  1  high in DONE
- fail  output  1  high in FAIL
- guess_count  output  4  number of guesses presented this game, including the current one

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state IDLE, guess=16'heeee, guess_valid=0, busy=0, solved=0, fail=0, guess_count=0, history count=0, candidate=FIRST_CAND.
- Reset mid-operation aborts immediately to these values.
- FSM states: IDLE, SEARCH, PRESENT, DONE, FAIL. Outputs are registered or decoded directly from state.
- IDLE/DONE/FAIL:
  - start → SEARCH, candidate=FIRST_CAND, history count=0, guess_count=0, guess=16'heeee.
  - start is ignored in SEARCH and PRESENT.
- SEARCH: one candidate is evaluated per clock.
  - The candidate is rejected if any nibble > 9 or any two digits are equal.
  - The candidate is also rejected if, for any stored entry h < count, score(candidate vs h.guess) != (h.a, h.b).
  - All stored entries are compared in parallel in the same cycle.
- Score definition: A = positions with equal digits. B = digits of one word present in the other at a different position. Both words have distinct digits.
- Accept: next edge → PRESENT, guess<=candidate, guess_count+=1.
- Reject with candidate==16'h9876 → FAIL; the search space is exhausted.
- Otherwise candidate <= BCD increment: the low nibble 9 wraps to 0 with a carry.
- PRESENT: guess_valid=1 and guess is held stable. fb_valid is ignored in every other state.
- On fb_valid in PRESENT:
  - Illegal feedback (fb_a>4, fb_b>4, fb_a+fb_b>4, or fb_a==3 && fb_b==1) → FAIL.
  - fb_a==4 → DONE; guess is held, guess_count is held.
  - history count==MAX_HIST → FAIL.
  - Otherwise store {guess, fb_a, fb_b} at index count, count+=1, candidate<=BCD increment of guess, → SEARCH.
  - If guess==16'h9876 and the score is not a win → FAIL.
- Latency:
  - start sampled at edge k → SEARCH; the first PRESENT is at edge k+1 when FIRST_CAND is consistent.
  - After feedback at edge j, each rejected candidate adds exactly one cycle.
- guess_count saturates at 15.
- History registers are not cleared on start; only count is reset, and entries ≥ count are don't-care.
- Simultaneous start and fb_valid: start wins only in IDLE/DONE/FAIL. fb_valid wins only in PRESENT. The two cannot both act in one cycle.

Test Plan:
- Immediate win: reset, start at edge k, then fb (4,0) at the first guess_valid.
  - guess=16'h0123 and guess_valid=1 after edge k+1.
  - After feedback: solved=1, guess_count=1, busy=0.
- Second-guess win: secret 4567, fb (0,0) for 0123.
  - Next guess=16'h4567 with guess_count=2.
  - fb (4,0) → solved=1.
- Exhaustion: secret 4567; fb (0,0) for 0123, then (0,0) for 4567.
  - Only digits 8 and 9 remain, so the search ends at candidate 9876.
  - fail=1, guess_valid=0.
- Illegal feedback: fb (3,1) or (2,3) on the first guess → fail=1 on the next edge.
- Ignore rules:
  - fb_valid pulsed during SEARCH and during IDLE has no effect on history or guess_count.
  - start pulsed during PRESENT leaves guess unchanged.
- Async reset: assert rst_n=0 mid-SEARCH, between clock edges.
  - All outputs reach their reset values immediately.
  - A later start reproduces the guess 16'h0123.
